// File: rtl/mode_select_debounce_pkg.sv
// Shared types and constants for the mode-select front end.
package mode_select_pkg;

   typedef enum logic [1:0] {
      NONE   = 2'd0,
      BLANK  = 2'd1,
      ACTIVE = 2'd2
   } mode_state_t;

   localparam logic [2:0] MODE_NONE  = 3'b000;
   localparam logic [2:0] MODE_ONE   = 3'b001;
   localparam logic [2:0] MODE_TWO   = 3'b010;
   localparam logic [2:0] MODE_THREE = 3'b100;

endpackage

// File: rtl/mode_select_debounce_if.sv
// Raw switch inputs and resolved mode outputs of the mode-select stage.
interface mode_select_debounce_if;
   logic       module_one;
   logic       module_two;
   logic       module_three;
   logic [2:0] mode_onehot;
   logic       mode_valid;
   logic       mode_change;

   // Switch side: drives the raw switches, observes the mode.
   modport master (
      output module_one, module_two, module_three,
      input  mode_onehot, mode_valid, mode_change
   );

   // Mode-select block side.
   modport slave (
      input  module_one, module_two, module_three,
      output mode_onehot, mode_valid, mode_change
   );
endinterface

// File: rtl/mode_select_debounce_switch.sv
// Two-flop synchroniser plus debouncer for one raw switch. The debounce timer
// is a down-counter: 0 means idle, the first mismatch cycle loads it and the
// level flips when the mismatch has lasted DEBOUNCE_CYCLES consecutive cycles.
module switch_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic CLOCK_50,
   input  logic RESET_N,
   input  logic raw_in,
   output logic level
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DW-1:0] DB_RELOAD = DW'(DEBOUNCE_CYCLES - 1);
   localparam bit SINGLE_CYCLE = (DEBOUNCE_CYCLES == 1);

   logic          sync_1;
   logic          sync_2;
   logic [DW-1:0] db_cnt;
   logic          db_done;

   // Terminal count: last cycle of a DEBOUNCE_CYCLES-long mismatch.
   assign db_done = SINGLE_CYCLE || (db_cnt == DW'(1));

   // Bring the asynchronous switch into the clk domain.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
      end else begin
         sync_1 <= raw_in;
         sync_2 <= sync_1;
      end
   end

   // Accept a new level only after it has been stable long enough.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         level  <= 1'b0;
         db_cnt <= '0;
      end else if (sync_2 != level) begin
         if (db_done) begin
            level  <= sync_2;
            db_cnt <= '0;
         end else if (db_cnt == '0) begin
            db_cnt <= DB_RELOAD;
         end else begin
            db_cnt <= db_cnt - DW'(1);
         end
      end else begin
         db_cnt <= '0;
      end
   end
endmodule

// File: rtl/mode_select_debounce.sv
// Debounces the three mode switches, resolves them by priority
// (one > two > three) into a registered one-hot mode, and blanks
// mode_valid for BLANK_CYCLES after every mode change.
//
// state  | meaning
// NONE   | no switch accepted since reset, mode_onehot = 000
// BLANK  | mode just changed, downstream settling, mode_valid = 0
// ACTIVE | mode settled, mode_valid = 1
module mode_select_debounce
   import mode_select_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int BLANK_CYCLES    = 50000
) (
   input  logic                  CLOCK_50,
   input  logic                  RESET_N,
   mode_select_debounce_if.slave bus
);
   localparam int BW = $clog2(BLANK_CYCLES + 1);
   localparam logic [BW-1:0] BLANK_RELOAD = BW'(BLANK_CYCLES - 1);

   logic          db_one;
   logic          db_two;
   logic          db_three;
   logic [2:0]    mode_req;
   logic [2:0]    mode_q;
   logic          valid_q;
   logic          change_q;
   logic [BW-1:0] blank_cnt;
   mode_state_t   state;

   switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_one (
      .CLOCK_50 (CLOCK_50),
      .RESET_N  (RESET_N),
      .raw_in   (bus.module_one),
      .level    (db_one)
   );

   switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_two (
      .CLOCK_50 (CLOCK_50),
      .RESET_N  (RESET_N),
      .raw_in   (bus.module_two),
      .level    (db_two)
   );

   switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_three (
      .CLOCK_50 (CLOCK_50),
      .RESET_N  (RESET_N),
      .raw_in   (bus.module_three),
      .level    (db_three)
   );

   // Fixed-priority request; releasing every switch holds the current mode.
   always_comb begin
      mode_req = mode_q;
      if (db_one) begin
         mode_req = MODE_ONE;
      end else if (db_two) begin
         mode_req = MODE_TWO;
      end else if (db_three) begin
         mode_req = MODE_THREE;
      end
   end

   // Mode register, blanking down-counter and registered outputs.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state     <= NONE;
         mode_q    <= MODE_NONE;
         valid_q   <= 1'b0;
         change_q  <= 1'b0;
         blank_cnt <= '0;
      end else begin
         change_q <= 1'b0;
         // A new request always restarts blanking, whatever the state.
         if (mode_req != mode_q) begin
            state     <= BLANK;
            mode_q    <= mode_req;
            change_q  <= 1'b1;
            valid_q   <= 1'b0;
            blank_cnt <= BLANK_RELOAD;
         end else begin
            case (state)
               BLANK: begin
                  if (blank_cnt == '0) begin
                     state   <= ACTIVE;
                     valid_q <= 1'b1;
                  end else begin
                     blank_cnt <= blank_cnt - BW'(1);
                  end
               end
               ACTIVE:  valid_q <= 1'b1;
               default: valid_q <= 1'b0;
            endcase
         end
      end
   end

   assign bus.mode_onehot = mode_q;
   assign bus.mode_valid  = valid_q;
   assign bus.mode_change = change_q;
endmodule

// File: tb/tb_mode_select_debounce.sv
// Directed bench for mode_select_debounce with DEBOUNCE_CYCLES=4, BLANK_CYCLES=3.
// Inputs change 1 ns after a rising edge; outputs are checked at the same point.
// A switch raised after edge 0 updates the mode after edge 7 (2 sync + 4 + 1).
module tb_mode_select_debounce;
   logic CLOCK_50 = 1'b0;
   logic RESET_N  = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   mode_select_debounce_if bus ();

   mode_select_debounce #(
      .DEBOUNCE_CYCLES (4),
      .BLANK_CYCLES    (3)
   ) dut (
      .CLOCK_50 (CLOCK_50),
      .RESET_N  (RESET_N),
      .bus      (bus)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [2:0] m, input logic v, input logic c);
      check_eq({tag, " mode"},   32'(bus.mode_onehot), 32'(m));
      check_eq({tag, " valid"},  32'(bus.mode_valid),  32'(v));
      check_eq({tag, " change"}, 32'(bus.mode_change), 32'(c));
   endtask

   initial begin
      bus.module_one   = 1'b0;
      bus.module_two   = 1'b0;
      bus.module_three = 1'b0;

      // Reset held while switches toggle: outputs stay at reset values.
      for (int i = 1; i <= 10; i++) begin
         tick();
         bus.module_one   = i[0];
         bus.module_two   = ~i[0];
         bus.module_three = i[1];
         check_out($sformatf("rst%0d", i), 3'b000, 1'b0, 1'b0);
      end
      bus.module_one   = 1'b0;
      bus.module_two   = 1'b0;
      bus.module_three = 1'b0;
      tick();
      RESET_N = 1'b1;
      tick();
      check_out("post_rst", 3'b000, 1'b0, 1'b0);

      // module_two raised: mode 010 after edge 7, valid from edge 10.
      bus.module_two = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         check_out($sformatf("two%0d", i), (i >= 7) ? 3'b010 : 3'b000,
                   (i >= 10), (i == 7));
      end

      // 3-cycle glitch on module_one is rejected.
      bus.module_one = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (i == 3) bus.module_one = 1'b0;
         check_out($sformatf("glitch%0d", i), 3'b010, 1'b1, 1'b0);
      end

      // Releasing every switch holds the mode.
      bus.module_two = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         check_out($sformatf("hold%0d", i), 3'b010, 1'b1, 1'b0);
      end

      // one and three together: one wins, single pulse.
      bus.module_one   = 1'b1;
      bus.module_three = 1'b1;
      for (int i = 1; i <= 11; i++) begin
         tick();
         check_out($sformatf("one_three%0d", i), (i >= 7) ? 3'b001 : 3'b010,
                   (i < 7) || (i >= 10), (i == 7));
      end

      // Release one with three still high: mode 100, valid low for 3 cycles.
      bus.module_one = 1'b0;
      for (int i = 1; i <= 11; i++) begin
         tick();
         check_out($sformatf("to_three%0d", i), (i >= 7) ? 3'b100 : 3'b001,
                   (i < 7) || (i >= 10), (i == 7));
      end

      // Drop three and raise two in the same cycle: mode 010.
      bus.module_three = 1'b0;
      bus.module_two   = 1'b1;
      for (int i = 1; i <= 11; i++) begin
         tick();
         check_out($sformatf("to_two%0d", i), (i >= 7) ? 3'b010 : 3'b100,
                   (i < 7) || (i >= 10), (i == 7));
      end

      // Request 100, then module_one lands during its blanking window.
      bus.module_two   = 1'b0;
      bus.module_three = 1'b1;
      for (int i = 1; i <= 14; i++) begin
         tick();
         if (i == 2) bus.module_one = 1'b1;
         check_out($sformatf("reblank%0d", i),
                   (i >= 9) ? 3'b001 : ((i >= 7) ? 3'b100 : 3'b010),
                   (i < 7) || (i >= 12), (i == 7) || (i == 9));
      end

      // Release one (three high) and assert reset mid-blank.
      bus.module_one = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         check_out($sformatf("pre_rst%0d", i), (i >= 7) ? 3'b100 : 3'b001,
                   (i < 7), (i == 7));
      end
      RESET_N = 1'b0;
      #2;
      check_out("async_rst", 3'b000, 1'b0, 1'b0);
      bus.module_three = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         check_out($sformatf("rst_hold%0d", i), 3'b000, 1'b0, 1'b0);
      end
      RESET_N = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         check_out($sformatf("after_rst%0d", i), 3'b000, 1'b0, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
